// File: rtl/exe_stage_mc.sv
// Purpose : ARM execute stage (operand-2 shifter, ALU, branch target) with a multi-cycle MUL, registered into EXE/MEM.
// Latency : 1 cycle for ALU ops, MUL_CYCLES cycles for MUL; every frozen cycle adds one.
// Backpressure: in_ready drops while a MUL is in flight, under freeze, flush or reset; freeze holds all state.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           ID/EXE handshake (accept = in_valid & in_ready)
//   flush, freeze                 discard in-flight work / hold everything (MEM stall)
//   wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm, exe_cmd, sr, dest_in,
//   shift_operand, imm_signed_24, pc_in, val_rn, val_rm     decoded instruction fields
//   out_valid, wb_en, mem_r_en, mem_w_en, status_wr, status, dest,
//   alu_result, br_addr, val_rm_out                         registered EXE/MEM outputs
module exe_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 24,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_in,
  input  logic              imm,
  input  logic [3:0]        exe_cmd,
  input  logic [3:0]        sr,
  input  logic [3:0]        dest_in,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  imm_signed_24,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              status_wr,
  output logic [3:0]        status,
  output logic [3:0]        dest,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] br_addr,
  output logic [DATA_W-1:0] val_rm_out
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // Rotate right; a zero amount must bypass the left shift (shift by DATA_W).
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input int unsigned r);
    logic [DATA_W-1:0] y;
    if (r == 0) y = x;
    else        y = (x >> r) | (x << (DATA_W - r));
    return y;
  endfunction

  // Returns {N,Z,C,V, result}. Undefined opcodes pass sr through with a zero result.
  function automatic logic [DATA_W+3:0] alu(input logic [3:0] cmd, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic [3:0] f);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] bo;
    logic [DATA_W-1:0] r;
    logic              cin, c, v, arith, known;
    sum   = '0;
    bo    = b;
    r     = '0;
    cin   = 1'b0;
    c     = f[1];
    v     = f[0];
    arith = 1'b0;
    known = 1'b1;
    case (cmd)
      OP_MOV: r = b;
      OP_MVN: r = ~b;
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; cin = f[1]; end
      // Subtraction as a + ~b + cin, so carry out means "no borrow".
      OP_SUB: begin arith = 1'b1; bo = ~b; cin = 1'b1; end
      OP_SBC: begin arith = 1'b1; bo = ~b; cin = f[1]; end
      default: known = 1'b0;
    endcase
    if (arith) begin
      sum = {1'b0, a} + {1'b0, bo} + {{DATA_W{1'b0}}, cin};
      r   = sum[DATA_W-1:0];
      c   = sum[DATA_W];
      v   = (a[DATA_W-1] == bo[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end
    if (known) return {r[DATA_W-1], (r == '0), c, v, r};
    else       return {f, {DATA_W{1'b0}}};
  endfunction

  logic [0:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q, wb_q, mr_q, mw_q, sw_q;
  logic [3:0]        status_q, dest_q;
  logic [DATA_W-1:0] res_q, br_q, rm_out_q;

  // Multiply operands and the controls of the instruction in flight.
  logic              m_wb_q, m_mr_q, m_mw_q, m_sw_q;
  logic [3:0]        m_dest_q, m_sr_q;
  logic [DATA_W-1:0] m_rn_q, m_rm_q, m_br_q;

  logic [DATA_W-1:0] val2, br_calc, mul_res;
  logic [DATA_W+3:0] alu_out;
  logic [3:0]        mul_flags;
  logic              accept;
  int unsigned       rot_amt;
  int unsigned       sh_amt;

  // Operand 2: memory offset, rotated 8-bit immediate, or shifted register.
  always_comb begin
    val2    = '0;
    rot_amt = (32'(shift_operand[11:8]) * 32'd2) % DATA_W;
    sh_amt  = 32'(shift_operand[11:7]);
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = DATA_W'(shift_operand);
    end else if (imm) begin
      val2 = ror(DATA_W'(shift_operand[7:0]), rot_amt);
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = val_rm << sh_amt;
        2'b01:   val2 = val_rm >> sh_amt;
        2'b10:   val2 = DATA_W'($signed(val_rm) >>> sh_amt);
        default: val2 = ror(val_rm, sh_amt % DATA_W);
      endcase
    end
  end

  assign alu_out   = alu(exe_cmd, val_rn, val2, sr);
  assign br_calc   = pc_in + DATA_W'($signed({imm_signed_24, 2'b00}));
  assign mul_res   = m_rn_q * m_rm_q;
  assign mul_flags = {mul_res[DATA_W-1], (mul_res == '0), m_sr_q[1:0]};

  // Depends only on state and the stall/kill inputs, never on in_valid.
  assign in_ready = (state_q == S_IDLE) && !freeze && !flush && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      sw_q        <= 1'b0;
      status_q    <= '0;
      dest_q      <= '0;
      res_q       <= '0;
      br_q        <= '0;
      rm_out_q    <= '0;
      m_wb_q      <= 1'b0;
      m_mr_q      <= 1'b0;
      m_mw_q      <= 1'b0;
      m_sw_q      <= 1'b0;
      m_dest_q    <= '0;
      m_sr_q      <= '0;
      m_rn_q      <= '0;
      m_rm_q      <= '0;
      m_br_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
    end else if (freeze) begin
      // Hold everything.
    end else if (state_q == S_MUL_BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        out_valid_q <= 1'b1;
        res_q       <= mul_res;
        status_q    <= mul_flags;
        wb_q        <= m_wb_q;
        mr_q        <= m_mr_q;
        mw_q        <= m_mw_q;
        sw_q        <= m_sw_q;
        dest_q      <= m_dest_q;
        br_q        <= m_br_q;
        rm_out_q    <= m_rm_q;
        state_q     <= S_IDLE;
        cnt_q       <= '0;
      end else begin
        out_valid_q <= 1'b0;
        cnt_q       <= cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      if (exe_cmd == OP_MUL) begin
        out_valid_q <= 1'b0;
        m_wb_q      <= wb_en_in;
        m_mr_q      <= mem_r_en_in;
        m_mw_q      <= mem_w_en_in;
        m_sw_q      <= s_in;
        m_dest_q    <= dest_in;
        m_sr_q      <= sr;
        m_rn_q      <= val_rn;
        m_rm_q      <= val_rm;
        m_br_q      <= br_calc;
        cnt_q       <= CNT_W'(MUL_CYCLES - 1);
        state_q     <= S_MUL_BUSY;
      end else begin
        out_valid_q <= 1'b1;
        res_q       <= alu_out[DATA_W-1:0];
        status_q    <= alu_out[DATA_W+3:DATA_W];
        wb_q        <= wb_en_in;
        mr_q        <= mem_r_en_in;
        mw_q        <= mem_w_en_in;
        sw_q        <= s_in;
        dest_q      <= dest_in;
        br_q        <= br_calc;
        rm_out_q    <= val_rm;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign wb_en      = wb_q & out_valid_q;
  assign mem_r_en   = mr_q & out_valid_q;
  assign mem_w_en   = mw_q & out_valid_q;
  assign status_wr  = sw_q & out_valid_q;
  assign status     = status_q;
  assign dest       = dest_q;
  assign alu_result = res_q;
  assign br_addr    = br_q;
  assign val_rm_out = rm_out_q;

endmodule
